// File: rtl/buffer_mc_if.sv
// Shared write/read port bundle for buffer_mc: one write port with channel select,
// one first-word-fall-through read port with channel select and delete.
interface buffer_mc_if #(
  parameter int WIDTH          = 32,
  parameter int LOG_N_CHANNELS = 2
);
  logic                      write_strobe;
  logic [LOG_N_CHANNELS-1:0] write_channel;
  logic [WIDTH-1:0]          write_data;
  logic [LOG_N_CHANNELS-1:0] read_channel;
  logic                      read_delete;
  logic                      read_full;
  logic [WIDTH-1:0]          read_data;

  modport master (
    output write_strobe, write_channel, write_data, read_channel, read_delete,
    input  read_full, read_data
  );

  modport slave (
    input  write_strobe, write_channel, write_data, read_channel, read_delete,
    output read_full, read_data
  );
endinterface

// File: rtl/buffer_mc.sv
// Multi-channel first-word-fall-through buffer: N_CHANNELS FIFOs in one shared array.
// Define BUFFER_MC_ALMOST_FULL_EN to add the registered per-channel almost_full port.
module buffer_mc #(
  parameter int WIDTH          = 32,
  parameter int N_CHANNELS     = 4,
  parameter int LOG_N_CHANNELS = 2,
  parameter int DEPTH          = 16,
  parameter int LOG_DEPTH      = 4,
  parameter int ALMOST_FULL    = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  buffer_mc_if.slave                          bus,
  output logic [N_CHANNELS*(LOG_DEPTH+1)-1:0] count,
`ifdef BUFFER_MC_ALMOST_FULL_EN
  output logic [N_CHANNELS-1:0]               almost_full,
`endif
  output logic [N_CHANNELS-1:0]               write_error,
  output logic [N_CHANNELS-1:0]               read_error
);

  localparam int CW = LOG_DEPTH + 1;
  localparam int AW = LOG_N_CHANNELS + LOG_DEPTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if ((1 << LOG_N_CHANNELS) != N_CHANNELS || (1 << LOG_DEPTH) != DEPTH ||
      DEPTH < 2 || ALMOST_FULL > DEPTH) begin : g_bad_params
    $error("buffer_mc: inconsistent channel/depth/threshold parameters");
  end

  logic [WIDTH-1:0]     mem [N_CHANNELS*DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr [N_CHANNELS];
  logic [LOG_DEPTH-1:0] rd_ptr [N_CHANNELS];
  logic [CW-1:0]        cnt [N_CHANNELS];
  logic [CW-1:0]        cnt_next [N_CHANNELS];
  logic [N_CHANNELS-1:0] werr, rerr;

  logic                 del_ok, wr_ok, full;
  logic [CW-1:0]        sel_cnt;
  logic [LOG_DEPTH-1:0] sel_ptr;
  logic [AW-1:0]        rd_addr, wr_addr;

  // Read side is purely combinational so a delete exposes head+1 in the same cycle
  always_comb begin
    sel_cnt = cnt[bus.read_channel];
    sel_ptr = rd_ptr[bus.read_channel] + LOG_DEPTH'(bus.read_delete);
    rd_addr = {bus.read_channel, sel_ptr};
    wr_addr = {bus.write_channel, wr_ptr[bus.write_channel]};
    del_ok  = bus.read_delete && (sel_cnt != '0);
    // A full channel still accepts a write when the same cycle frees one of its slots
    wr_ok   = bus.write_strobe &&
              ((cnt[bus.write_channel] != FULL_CNT) ||
               (del_ok && (bus.write_channel == bus.read_channel)));
    full    = bus.read_delete ? (sel_cnt >= CW'(2)) : (sel_cnt != '0);
    bus.read_full = full;
    bus.read_data = full ? mem[rd_addr] : '0;
  end

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      cnt_next[c] = cnt[c];
      if (wr_ok && (bus.write_channel == LOG_N_CHANNELS'(c)) &&
          !(del_ok && (bus.read_channel == LOG_N_CHANNELS'(c))))
        cnt_next[c] = cnt[c] + CW'(1);
      else if (del_ok && (bus.read_channel == LOG_N_CHANNELS'(c)) &&
               !(wr_ok && (bus.write_channel == LOG_N_CHANNELS'(c))))
        cnt_next[c] = cnt[c] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      werr <= '0;
      rerr <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) cnt[c] <= cnt_next[c];
      if (wr_ok)
        wr_ptr[bus.write_channel] <= wr_ptr[bus.write_channel] + LOG_DEPTH'(1);
      else if (bus.write_strobe)
        werr[bus.write_channel] <= 1'b1;
      if (del_ok)
        rd_ptr[bus.read_channel] <= rd_ptr[bus.read_channel] + LOG_DEPTH'(1);
      else if (bus.read_delete)
        rerr[bus.read_channel] <= 1'b1;
    end
  end

  // Storage is data only; it is never cleared, just made unreachable by the pointers
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_addr] <= bus.write_data;
  end

`ifdef BUFFER_MC_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_CNT = CW'(ALMOST_FULL);
  logic [N_CHANNELS-1:0] af;

  always_ff @(posedge clk) begin
    if (rst) begin
      af <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) af[c] <= (cnt_next[c] >= AF_CNT);
    end
  end

  assign almost_full = af;
`endif

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_count
    assign count[g*CW +: CW] = cnt[g];
  end

  assign write_error = werr;
  assign read_error  = rerr;

endmodule

// File: tb/tb_buffer_mc.sv
// Randomised and directed bench for buffer_mc against a queue-per-channel reference model.
module tb_buffer_mc;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int LNC   = 2;
  localparam int DEPTH = 16;
  localparam int LD    = 4;
  localparam int AF    = 12;
  localparam int CW    = LD + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_mc_if #(.WIDTH(WIDTH), .LOG_N_CHANNELS(LNC)) bus ();

  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    write_error;
  logic [NCH-1:0]    read_error;
`ifdef BUFFER_MC_ALMOST_FULL_EN
  logic [NCH-1:0]    almost_full;
`endif

  buffer_mc #(
    .WIDTH(WIDTH), .N_CHANNELS(NCH), .LOG_N_CHANNELS(LNC),
    .DEPTH(DEPTH), .LOG_DEPTH(LD), .ALMOST_FULL(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .count(count),
`ifdef BUFFER_MC_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .write_error(write_error),
    .read_error(read_error)
  );

  // Reference model: one queue per channel plus sticky flags
  logic [WIDTH-1:0] mq [NCH][$];
  logic [NCH-1:0]   m_werr;
  logic [NCH-1:0]   m_rerr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_regs();
    logic [NCH*CW-1:0] e_cnt;
    logic [NCH-1:0]    e_af;
    for (int c = 0; c < NCH; c++) begin
      e_cnt[c*CW +: CW] = CW'(mq[c].size());
      e_af[c] = (mq[c].size() >= AF);
    end
    check("count", 64'(count), 64'(e_cnt));
    check("write_error", 64'(write_error), 64'(m_werr));
    check("read_error", 64'(read_error), 64'(m_rerr));
`ifdef BUFFER_MC_ALMOST_FULL_EN
    check("almost_full", 64'(almost_full), 64'(e_af));
`endif
  endtask

  task automatic step(input logic r, input logic ws, input logic [LNC-1:0] wc,
                      input logic [WIDTH-1:0] wd, input logic [LNC-1:0] rc, input logic rd);
    int               idx;
    logic             e_full;
    logic [WIDTH-1:0] e_data;
    bit               del_ok;
    @(negedge clk);
    rst               = r;
    bus.write_strobe  = ws;
    bus.write_channel = wc;
    bus.write_data    = wd;
    bus.read_channel  = rc;
    bus.read_delete   = rd;
    #1;
    idx    = rd ? 1 : 0;
    e_full = (mq[rc].size() > idx);
    e_data = e_full ? mq[rc][idx] : '0;
    check("read_full", 64'(bus.read_full), 64'(e_full));
    check("read_data", 64'(bus.read_data), 64'(e_data));
    @(posedge clk);
    if (r) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_werr = '0;
      m_rerr = '0;
    end else begin
      del_ok = 1'b0;
      if (rd) begin
        if (mq[rc].size() > 0) begin
          void'(mq[rc].pop_front());
          del_ok = 1'b1;
        end else begin
          m_rerr[rc] = 1'b1;
        end
      end
      if (ws) begin
        if (mq[wc].size() < DEPTH || (del_ok && wc == rc)) mq[wc].push_back(wd);
        else m_werr[wc] = 1'b1;
      end
    end
    #1;
    check_regs();
  endtask

  initial begin
    int ws_pct, rd_pct;
    rst = 1'b1;
    bus.write_strobe = 1'b0; bus.write_channel = '0; bus.write_data = '0;
    bus.read_channel = '0;   bus.read_delete = 1'b0;
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_werr = '0;
    m_rerr = '0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_count", 64'(count), 64'd0);

    // ch2: four words, head visible, other channels empty
    for (int i = 0; i < 4; i++) step(0, 1, 2, 32'hA0 + i, 0, 0);
    step(0, 0, 0, 0, 2, 0);
    check("ch2_head", 64'(bus.read_data), 64'hA0);
    check("ch2_count", 64'(count[2*CW +: CW]), 64'd4);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 3, 0);

    // ch2 drained by back-to-back deletes
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2, 1);
    check("ch2_drained", 64'(count[2*CW +: CW]), 64'd0);
    check("ch2_no_rerr", 64'(read_error[2]), 64'd0);

    // ch0 overflow
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h100 + i, 0, 0);
    step(0, 1, 0, 32'hDEAD, 0, 0);
    check("ch0_werr", 64'(write_error[0]), 64'd1);
    check("ch0_full", 64'(count[0 +: CW]), 64'd16);

    // ch1 full, simultaneous write and delete, then pointer wrap
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 32'h200 + i, 0, 0);
    step(0, 1, 1, 32'h55, 1, 1);
    check("ch1_still_full", 64'(count[1*CW +: CW]), 64'd16);
    check("ch1_no_werr", 64'(write_error[1]), 64'd0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    check("ch1_last", 64'(bus.read_data), 64'h55);

    // ch3 empty: delete with write
    step(0, 1, 3, 32'h77, 3, 1);
    check("ch3_rerr", 64'(read_error[3]), 64'd1);
    step(0, 0, 0, 0, 3, 0);
    check("ch3_data", 64'(bus.read_data), 64'h77);

    // reset with a concurrent write
    step(1, 1, 2, 32'h99, 0, 0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_werr", 64'(write_error), 64'd0);
    step(0, 0, 0, 0, 2, 0);

    // randomised traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      if ((i / 150) % 2 == 0) begin ws_pct = 85; rd_pct = 30; end
      else begin ws_pct = 30; rd_pct = 85; end
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 99) < ws_pct),
           LNC'($urandom_range(0, NCH - 1)),
           $urandom,
           LNC'($urandom_range(0, NCH - 1)),
           ($urandom_range(0, 99) < rd_pct));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
